deserializer: RTL and testbench

//  Receive end of the 4-bit serial link: rebuilds 64-bit flits from 16 nibbles, LSB nibble first.

---
 rtl/deserializer.sv | 204 ++++++++++++++++++++
 tb/tb_deserializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer
//  Description : Receive end of a 4-bit serial link. Rebuilds FLIT_W-bit
//                flits from NIBBLES nibbles (LSB nibble first), tags each
//                flit with the VC of its first nibble and queues it in a
//                small output FIFO drained through a valid/ready handshake.
//                The serial side cannot be stalled, so a completed flit
//                that finds the FIFO full (and no pop in the same cycle) is
//                dropped and overflow pulses for one cycle.
//  Optional    : define DESER_VC_CHECK_EN to abort a partial flit when the
//                VC changes mid-flit (vc_err pulses, the offending nibble
//                restarts assembly). Undefined: vc_err is tied to 0.
//  Ports       : clk, rst         clock / synchronous active-high reset
//                data_in[3:0]     serial nibble
//                valid_in         data_in / vc_in valid
//                vc_in[1:0]       VC of the current nibble
//                flit_out         head-of-FIFO flit (holds last value when empty)
//                flit_vc[1:0]     head-of-FIFO VC
//                flit_valid       FIFO non-empty
//                flit_ready       consumer accepts the head
//                fifo_count       occupied FIFO entries
//                overflow         1-cycle pulse: completed flit dropped
//                vc_err           1-cycle pulse: VC changed mid-flit
//  Revision    : 1.0  initial release
// ============================================================================
module deserializer #(
  parameter int FLIT_W     = 64,
  parameter int NIBBLES    = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        data_in,
  input  logic              valid_in,
  input  logic [1:0]        vc_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic [1:0]        flit_vc,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  output logic              vc_err
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------- assembly
  // Only the first NIBBLES-1 nibbles are buffered; the last one is taken
  // straight from data_in when the flit completes.
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FLIT_W-5:0]   buf_q, buf_d;
  logic [1:0]          vc_q, vc_d;
  logic                w_abort;
  logic                w_complete;
  logic [FLIT_W-1:0]   w_flit;

`ifdef DESER_VC_CHECK_EN
  assign w_abort = valid_in && (idx_q != '0) && (vc_in != vc_q);
`else
  assign w_abort = 1'b0;
`endif

  assign w_flit = {data_in, buf_q};

  always_comb begin
    idx_d      = idx_q;
    buf_d      = buf_q;
    vc_d       = vc_q;
    w_complete = 1'b0;
    if (valid_in) begin
      if (w_abort) begin
        // Offending nibble becomes nibble 0 of a fresh flit on its own VC.
        buf_d[3:0] = data_in;
        vc_d       = vc_in;
        idx_d      = IDX_W'(1);
      end else begin
        for (int i = 0; i < NIBBLES - 1; i++) begin
          if (idx_q == IDX_W'(i)) begin
            buf_d[i*4 +: 4] = data_in;
          end
        end
        if (idx_q == '0) begin
          vc_d = vc_in;
        end
        if (idx_q == C_LAST_IDX) begin
          idx_d      = '0;
          w_complete = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      buf_q <= '0;
      vc_q  <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
      vc_q  <= vc_d;
    end
  end

  // -------------------------------------------------------------------- FIFO
  logic [FLIT_W-1:0] mem_q   [FIFO_DEPTH];
  logic [1:0]        memvc_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [FLIT_W-1:0] head_q, head_d;
  logic [1:0]        headvc_q, headvc_d;
  logic              overflow_q, overflow_d;
  logic              w_pop;
  logic              w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_pop  = (count_q != '0) && flit_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_push = w_complete && ((count_q != C_DEPTH) || w_pop);

  always_comb begin
    overflow_d = w_complete && !w_push;
    rd_d       = w_pop  ? ptr_inc(rd_q) : rd_q;
    wr_d       = w_push ? ptr_inc(wr_q) : wr_q;
    count_d    = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (w_pop && !w_push) begin
      count_d = count_q - 1'b1;
    end
    // Registered head view: the next head is either the flit being written
    // into the slot the read pointer will point at, or existing storage.
    // When the FIFO goes empty the last head value is held.
    head_d   = head_q;
    headvc_d = headvc_q;
    if (count_d != '0) begin
      if (w_push && (wr_q == rd_d)) begin
        head_d   = w_flit;
        headvc_d = vc_q;
      end else begin
        head_d   = mem_q[rd_d];
        headvc_d = memvc_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_q]   <= w_flit;
      memvc_q[wr_q] <= vc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      head_q     <= '0;
      headvc_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      headvc_q   <= headvc_d;
      overflow_q <= overflow_d;
    end
  end

  assign flit_out   = head_q;
  assign flit_vc    = headvc_q;
  assign flit_valid = (count_q != '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

`ifdef DESER_VC_CHECK_EN
  logic vc_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      vc_err_q <= 1'b0;
    end else begin
      vc_err_q <= w_abort;
    end
  end
  assign vc_err = vc_err_q;
`else
  assign vc_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deserializer
//  Description : Self-checking bench for deserializer. A transaction-level
//                model (nibble queue -> flit, flit queue -> FIFO) predicts
//                every output each cycle; directed scenarios plus a random
//                stream drive the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_deserializer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  data_in;
  logic        valid_in;
  logic [1:0]  vc_in;
  logic [63:0] flit_out;
  logic [1:0]  flit_vc;
  logic        flit_valid;
  logic        flit_ready;
  logic [1:0]  fifo_count;
  logic        overflow;
  logic        vc_err;

  deserializer dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .vc_in      (vc_in),
    .flit_out   (flit_out),
    .flit_vc    (flit_vc),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .vc_err     (vc_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------- model
  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  vc;
  } flit_t;

  logic [3:0]  m_nib[$];
  logic [1:0]  m_vc;
  flit_t       m_fifo[$];
  logic [63:0] m_last_d;
  logic [1:0]  m_last_vc;
  logic        m_ovf;
  logic        m_vcerr;

  task automatic model_reset();
    m_nib.delete();
    m_fifo.delete();
    m_vc      = '0;
    m_last_d  = '0;
    m_last_vc = '0;
    m_ovf     = 1'b0;
    m_vcerr   = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] d, input logic [1:0] c, input logic r);
    flit_t f;
    logic  comp;
    logic  pop;
    comp    = 1'b0;
    m_ovf   = 1'b0;
    m_vcerr = 1'b0;
    pop     = (m_fifo.size() > 0) && r;
    f       = '0;
    if (v) begin
`ifdef DESER_VC_CHECK_EN
      if (m_nib.size() > 0 && c != m_vc) begin
        m_nib.delete();
        m_vcerr = 1'b1;
      end
`endif
      if (m_nib.size() == 0) m_vc = c;
      m_nib.push_back(d);
      if (m_nib.size() == 16) begin
        for (int i = 0; i < 16; i++) f.d = f.d | (64'(m_nib[i]) << (4 * i));
        f.vc = m_vc;
        m_nib.delete();
        comp = 1'b1;
      end
    end
    if (pop) m_fifo.delete(0);
    if (comp) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(f);
      else m_ovf = 1'b1;
    end
    if (m_fifo.size() > 0) begin
      m_last_d  = m_fifo[0].d;
      m_last_vc = m_fifo[0].vc;
    end
  endtask

  task automatic check_outputs();
    check("flit_valid", flit_valid, m_fifo.size() > 0);
    check("fifo_count", fifo_count, 64'(m_fifo.size()));
    check("flit_out",   flit_out,   m_last_d);
    check("flit_vc",    flit_vc,    m_last_vc);
    check("overflow",   overflow,   m_ovf);
    check("vc_err",     vc_err,     m_vcerr);
  endtask

  // One clock cycle: drive, predict, clock, compare.
  task automatic cyc(input logic v, input logic [3:0] d, input logic [1:0] c, input logic r);
    valid_in   = v;
    data_in    = d;
    vc_in      = c;
    flit_ready = r;
    model_step(v, d, c, r);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    valid_in   = 1'b0;
    data_in    = '0;
    vc_in      = '0;
    flit_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();
  endtask

  task automatic send_flit(input logic [63:0] f, input logic [1:0] c, input logic r_last);
    logic [63:0] t;
    t = f;
    for (int i = 0; i < 16; i++) cyc(1'b1, t[i*4 +: 4], c, (i == 15) ? r_last : 1'b0);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 2'd0, r);
  endtask

  initial begin
    logic [1:0] rvc;
    model_reset();
    do_reset();

    // 1: nibbles 0..F on VC 2
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 2'd2, 1'b0);
    check("case1_data", flit_out, 64'hFEDCBA9876543210);
    check("case1_vc",   flit_vc,  2'd2);
    idle(1, 1'b1);

    // 2: fill, overflow on third, drain in order; output holds once empty
    send_flit(64'h1111111111111111, 2'd1, 1'b0);
    send_flit(64'h2222222222222222, 2'd3, 1'b0);
    check("case2_full", fifo_count, 2'd2);
    send_flit(64'h3333333333333333, 2'd0, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);
    check("case2_hold", flit_out, 64'h2222222222222222);

    // 3: full FIFO with pop on the completing cycle
    send_flit(64'hAAAAAAAAAAAAAAAA, 2'd1, 1'b0);
    send_flit(64'hBBBBBBBBBBBBBBBB, 2'd2, 1'b0);
    send_flit(64'hCCCCCCCCCCCCCCCC, 2'd3, 1'b1);
    check("case3_head", flit_out, 64'hBBBBBBBBBBBBBBBB);
    idle(1, 1'b1);
    check("case3_new", flit_out, 64'hCCCCCCCCCCCCCCCC);
    idle(2, 1'b1);

    // 4: valid gaps after nibbles 5 and 12
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 4'(i), 2'd2, 1'b0);
      if (i == 5 || i == 12) idle(3, 1'b0);
    end
    check("case4_data", flit_out, 64'hFEDCBA9876543210);
    idle(1, 1'b1);

    // 5: reset mid-flit discards the partial flit
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'hF, 2'd3, 1'b0);
    do_reset();
    send_flit(64'h0123456789ABCDEF, 2'd1, 1'b0);
    check("case5_data", flit_out, 64'h0123456789ABCDEF);
    idle(2, 1'b1);

    // 6: VC change mid-flit
    for (int i = 0; i < 8; i++)  cyc(1'b1, 4'(i), 2'd1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(15 - i), 2'd3, 1'b0);
    idle(2, 1'b1);
    do_reset();

    // random stream with occasional VC changes and one reset
    rvc = 2'd0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 39) == 0) rvc = 2'($urandom);
      if (n == 1200) do_reset();
      cyc($urandom_range(0, 9) < 8, 4'($urandom), rvc, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
